// File: rtl/mux8_sel_scheduler_if.sv
// Request/grant bundle between the requesting sources and the 8:1 mux scheduler.
interface mux8_sel_scheduler_if;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic       s0;
  logic       s1;
  logic       s2;
  logic       preempt;

  // Requester side: drives enable and requests, observes grants.
  modport master (
    output en, req,
    input  gnt, gnt_valid, s0, s1, s2, preempt
  );

  // Scheduler side: samples requests, drives grant and mux selects.
  modport slave (
    input  en, req,
    output gnt, gnt_valid, s0, s1, s2, preempt
  );
endinterface

// File: rtl/mux8_sel_scheduler.sv
// Round-robin scheduler for a shared 8:1 mux. Drives a one-hot grant plus the
// binary mux select, and preempts a long-held grant when others are waiting.
module mux8_sel_scheduler #(
  parameter int unsigned MAX_HOLD = 16,  // 0 disables the hold timeout
  parameter int unsigned CNT_W    = 5    // 2**CNT_W must exceed MAX_HOLD
) (
  input logic                  clk,
  input logic                  rst,
  mux8_sel_scheduler_if.slave  bus
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  localparam bit              HoldLimit = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HoldLast  = HoldLimit ? CNT_W'(MAX_HOLD - 1) : '0;

  // First requester after `from`, wrapping modulo 8; `from` itself is checked last.
  function automatic logic [2:0] pick(input logic [2:0] from, input logic [7:0] reqs);
    logic [2:0] idx;
    logic       found;
    pick  = from;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = from + 3'(k);
      if (!found && reqs[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  state_e           state_q, state_d;
  logic [7:0]       gnt_q, gnt_d;
  logic             valid_q, valid_d;
  logic [2:0]       sel_q, sel_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             preempt_q, preempt_d;

  logic             cur_req;
  logic [7:0]       others;
  logic             do_grant;
  logic [2:0]       from_idx;
  logic [2:0]       next_idx;

  assign cur_req = bus.req[sel_q];
  assign others  = bus.req & ~(8'b1 << sel_q);

  // Next-state: decide whether to grant, release, preempt or keep holding.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    valid_d   = valid_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;
    do_grant  = 1'b0;
    from_idx  = ptr_q;
    next_idx  = '0;

    unique case (state_q)
      StIdle: begin
        if (bus.en && (|bus.req)) begin
          do_grant = 1'b1;
          from_idx = ptr_q;
        end
      end
      StBusy: begin
        if (!cur_req) begin
          // Release wins over a coincident timeout, so preempt stays low here.
          if (bus.en && (|bus.req)) begin
            do_grant = 1'b1;
            from_idx = sel_q;
          end else begin
            state_d = StIdle;
            gnt_d   = '0;
            valid_d = 1'b0;
          end
        end else if (HoldLimit && (hold_q == HoldLast) && bus.en && (|others)) begin
          do_grant  = 1'b1;
          from_idx  = sel_q;
          preempt_d = 1'b1;
        end else if (HoldLimit && (hold_q != HoldLast)) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (do_grant) begin
      next_idx = pick(from_idx, bus.req);
      state_d  = StBusy;
      gnt_d    = 8'b1 << next_idx;
      valid_d  = 1'b1;
      sel_d    = next_idx;
      ptr_d    = next_idx;
      hold_d   = '0;
    end
  end

  // State and registered outputs; reset drops any grant immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      gnt_q     <= '0;
      valid_q   <= 1'b0;
      sel_q     <= '0;
      ptr_q     <= 3'd7;
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      valid_q   <= valid_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end

  assign bus.gnt              = gnt_q;
  assign bus.gnt_valid        = valid_q;
  assign {bus.s2, bus.s1, bus.s0} = sel_q;
  assign bus.preempt          = preempt_q;

endmodule

// File: tb/tb_mux8_sel_scheduler.sv
// Self-checking bench for mux8_sel_scheduler: vector table, directed corner
// sequences and randomized traffic against a behavioural round-robin model.
module tb_mux8_sel_scheduler;

  localparam int MaxHold = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mux8_sel_scheduler_if bus ();

  mux8_sel_scheduler #(
    .MAX_HOLD (MaxHold),
    .CNT_W    (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: owner, pointer and how many cycles the grant has been visible.
  bit m_valid;
  int m_sel;
  int m_ptr;
  int m_age;
  bit m_pre;

  typedef struct {
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic       valid;
    logic [2:0] sel;
    logic       pre;
  } vec_t;

  vec_t tbl[28];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input int from, input logic [7:0] reqs);
    for (int k = 1; k <= 8; k++) begin
      if (reqs[(from + k) % 8]) return (from + k) % 8;
    end
    return from;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_sel   = 0;
    m_ptr   = 7;
    m_age   = 0;
    m_pre   = 1'b0;
  endtask

  task automatic model_grant(input int idx);
    m_valid = 1'b1;
    m_sel   = idx;
    m_ptr   = idx;
    m_age   = 1;
  endtask

  task automatic model_step(input logic en, input logic [7:0] reqs);
    logic [7:0] rivals;
    m_pre  = 1'b0;
    rivals = reqs;
    if (m_valid) rivals[m_sel] = 1'b0;
    if (!m_valid) begin
      if (en && reqs != 0) model_grant(rr_pick(m_ptr, reqs));
    end else if (!reqs[m_sel]) begin
      if (en && reqs != 0) model_grant(rr_pick(m_sel, reqs));
      else m_valid = 1'b0;
    end else if (MaxHold != 0 && m_age >= MaxHold && en && rivals != 0) begin
      model_grant(rr_pick(m_sel, reqs));
      m_pre = 1'b1;
    end else begin
      m_age++;
    end
  endtask

  function automatic logic [2:0] dut_sel();
    return {bus.s2, bus.s1, bus.s0};
  endfunction

  task automatic compare_model();
    logic [7:0] exp_gnt;
    exp_gnt = m_valid ? (8'b1 << m_sel) : 8'h00;
    check("no_x", 32'($isunknown({bus.gnt, bus.gnt_valid, bus.s2, bus.s1, bus.s0,
                                  bus.preempt})), 32'd0);
    check("onehot0", 32'($onehot0(bus.gnt)), 32'd1);
    check("valid_or", 32'(bus.gnt_valid), 32'(|bus.gnt));
    if (bus.gnt_valid) check("gnt_sel", 32'(bus.gnt), 32'(8'b1 << dut_sel()));
    check("model_gnt", 32'(bus.gnt), 32'(exp_gnt));
    check("model_valid", 32'(bus.gnt_valid), 32'(m_valid));
    check("model_sel", 32'(dut_sel()), 32'(m_sel));
    check("model_preempt", 32'(bus.preempt), 32'(m_pre));
  endtask

  task automatic step();
    @(posedge clk);
    model_step(bus.en, bus.req);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    bus.en  = 1'b0;
    bus.req = 8'h00;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic fill_table();
    tbl[0]  = '{1'b0, 8'h10, 8'h00, 1'b0, 3'd0, 1'b0};
    tbl[1]  = '{1'b1, 8'h10, 8'h10, 1'b1, 3'd4, 1'b0};
    tbl[2]  = '{1'b0, 8'h10, 8'h10, 1'b1, 3'd4, 1'b0};
    tbl[3]  = '{1'b0, 8'h11, 8'h10, 1'b1, 3'd4, 1'b0};
    tbl[4]  = '{1'b0, 8'h11, 8'h10, 1'b1, 3'd4, 1'b0};
    tbl[5]  = '{1'b0, 8'h11, 8'h10, 1'b1, 3'd4, 1'b0};
    tbl[6]  = '{1'b1, 8'h11, 8'h01, 1'b1, 3'd0, 1'b1};
    tbl[7]  = '{1'b1, 8'h29, 8'h01, 1'b1, 3'd0, 1'b0};
    tbl[8]  = '{1'b1, 8'h28, 8'h08, 1'b1, 3'd3, 1'b0};
    tbl[9]  = '{1'b1, 8'h20, 8'h20, 1'b1, 3'd5, 1'b0};
    tbl[10] = '{1'b1, 8'h09, 8'h01, 1'b1, 3'd0, 1'b0};
    tbl[11] = '{1'b1, 8'h08, 8'h08, 1'b1, 3'd3, 1'b0};
    tbl[12] = '{1'b1, 8'h00, 8'h00, 1'b0, 3'd3, 1'b0};
    tbl[13] = '{1'b1, 8'h80, 8'h80, 1'b1, 3'd7, 1'b0};
    tbl[14] = '{1'b1, 8'h80, 8'h80, 1'b1, 3'd7, 1'b0};
    tbl[15] = '{1'b1, 8'h81, 8'h80, 1'b1, 3'd7, 1'b0};
    tbl[16] = '{1'b1, 8'h01, 8'h01, 1'b1, 3'd0, 1'b0};
    tbl[17] = '{1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0};
    tbl[18] = '{1'b1, 8'h01, 8'h01, 1'b1, 3'd0, 1'b0};
    tbl[19] = '{1'b1, 8'h01, 8'h01, 1'b1, 3'd0, 1'b0};
    tbl[20] = '{1'b1, 8'h01, 8'h01, 1'b1, 3'd0, 1'b0};
    tbl[21] = '{1'b1, 8'h01, 8'h01, 1'b1, 3'd0, 1'b0};
    tbl[22] = '{1'b1, 8'h01, 8'h01, 1'b1, 3'd0, 1'b0};
    tbl[23] = '{1'b1, 8'h03, 8'h02, 1'b1, 3'd1, 1'b1};
    tbl[24] = '{1'b1, 8'h03, 8'h02, 1'b1, 3'd1, 1'b0};
    tbl[25] = '{1'b1, 8'h03, 8'h02, 1'b1, 3'd1, 1'b0};
    tbl[26] = '{1'b1, 8'h03, 8'h02, 1'b1, 3'd1, 1'b0};
    tbl[27] = '{1'b1, 8'h01, 8'h01, 1'b1, 3'd0, 1'b0};
  endtask

  initial begin
    logic [7:0] r;
    bus.en  = 1'b0;
    bus.req = 8'h00;
    model_reset();
    fill_table();

    // Reset with all requests high, then first grant and full rotation.
    rst     = 1'b1;
    bus.en  = 1'b1;
    bus.req = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", 32'(bus.gnt), 32'h0);
    check("rst_valid", 32'(bus.gnt_valid), 32'h0);
    check("rst_sel", 32'(dut_sel()), 32'h0);
    check("rst_preempt", 32'(bus.preempt), 32'h0);
    rst = 1'b0;
    model_reset();
    step();
    check("first_gnt", 32'(bus.gnt), 32'h01);
    for (int n = 0; n < 8; n++) begin
      repeat (2) begin
        step();
        check("rot_hold", 32'(bus.gnt), 32'(8'b1 << n));
      end
      bus.req = 8'hFF & ~(8'b1 << n);
      step();
      bus.req = 8'hFF;
      check("rot_next", 32'(bus.gnt), 32'(8'b1 << ((n + 1) % 8)));
      check("rot_valid", 32'(bus.gnt_valid), 32'h1);
    end

    // Vector table.
    do_reset();
    for (int i = 0; i < 28; i++) begin
      bus.en  = tbl[i].en;
      bus.req = tbl[i].req;
      step();
      check($sformatf("tbl%0d_gnt", i), 32'(bus.gnt), 32'(tbl[i].gnt));
      check($sformatf("tbl%0d_valid", i), 32'(bus.gnt_valid), 32'(tbl[i].valid));
      check($sformatf("tbl%0d_sel", i), 32'(dut_sel()), 32'(tbl[i].sel));
      check($sformatf("tbl%0d_pre", i), 32'(bus.preempt), 32'(tbl[i].pre));
    end

    // Timeout between sources 2 and 6.
    do_reset();
    bus.en  = 1'b1;
    bus.req = 8'h44;
    step();
    check("to_first", 32'(bus.gnt), 32'h04);
    repeat (3) begin
      step();
      check("to_hold2", 32'(bus.gnt), 32'h04);
    end
    step();
    check("to_gnt6", 32'(bus.gnt), 32'h40);
    check("to_pulse", 32'(bus.preempt), 32'h1);
    repeat (3) begin
      step();
      check("to_hold6", 32'(bus.gnt), 32'h40);
      check("to_pulse_end", 32'(bus.preempt), 32'h0);
    end
    step();
    check("to_back2", 32'(bus.gnt), 32'h04);
    check("to_pulse2", 32'(bus.preempt), 32'h1);

    // Asynchronous reset between edges while source 5 owns the mux.
    do_reset();
    bus.en  = 1'b1;
    bus.req = 8'h20;
    step();
    check("ar_pre", 32'(bus.gnt), 32'h20);
    #2;
    rst = 1'b1;
    #1;
    check("ar_gnt", 32'(bus.gnt), 32'h0);
    check("ar_valid", 32'(bus.gnt_valid), 32'h0);
    check("ar_sel", 32'(dut_sel()), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Randomized traffic against the model.
    r = 8'h00;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) r = r ^ 8'($urandom_range(0, 255));
      bus.req = r;
      bus.en  = ($urandom_range(0, 7) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
